dot_job_sequencer: RTL and testbench

Control block that drives the MLP `DotProduct` engine as its initiator. It loads an input vector and one weight row per neuron from a single-port operand memory into flattened operand buses. It then releases the engine, waits for `endf`, and streams each 32-bit IEEE-754 result out through a valid/ready port. It sits between the layer memory and the dot-product engine and runs one full layer per `start`.

---
 rtl/mlp_pkg.sv | 25 ++
 rtl/operand_loader.sv | 86 ++++++++
 rtl/dot_job_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_dot_job_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// Purpose : shared types and constants for the MLP layer datapath (sequencer FSM
//           encodings, FP constants, default layer geometry, operand address helper).
// Latency : n/a (package).  Backpressure: n/a (package).
package mlp_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_X = 3'd1,
    LOAD_W = 3'd2,
    RUN    = 3'd3,
    EMIT   = 3'd4
  } seq_state_t;

  // IEEE-754 single-precision quiet NaN, emitted when the engine never finishes.
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  localparam int VLEN_DEF    = 50;
  localparam int NEURONS_DEF = 10;

  // Operand memory base of weight row k: the input vector occupies the first VLEN words.
  function automatic int row_base(input int vlen, input int k);
    return vlen * (k + 1);
  endfunction

endpackage

// File: rtl/operand_loader.sv
// Purpose : issues a burst of VLEN consecutive operand reads and produces the
//           1-cycle-delayed element write strobe that lands each returned word.
// Latency : mem_rd one cycle after go_i; write strobe one cycle after each read.
// Backpressure: none, the burst always runs to completion once started.
//
// Ports:
//   clk_i, rst_ni         clock, async active-low reset
//   go_i, base_i, sel_i   start a burst at base_i; sel_i tags the target (0 = A, 1 = B)
//   mem_rd_o, mem_addr_o  read strobe / address towards the operand memory
//   last_o                final read of the burst is being issued this cycle
//   we_o, widx_o, wsel_o  write strobe, element index and target for the returning word
module operand_loader
  import mlp_pkg::*;
#(
  parameter int VLEN = VLEN_DEF,
  parameter int AW   = 10,
  localparam int IW  = (VLEN > 1) ? $clog2(VLEN) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          go_i,
  input  logic [AW-1:0] base_i,
  input  logic          sel_i,
  output logic          mem_rd_o,
  output logic [AW-1:0] mem_addr_o,
  output logic          last_o,
  output logic          we_o,
  output logic [IW-1:0] widx_o,
  output logic          wsel_o
);

  logic          active_q, active_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] base_q, base_d;
  logic          sel_q, sel_d;
  logic          we_q;
  logic [IW-1:0] widx_q;
  logic          wsel_q;

  assign last_o = active_q && (cnt_q == IW'(VLEN - 1));

  // A new go in the same cycle as the final read chains bursts without a gap.
  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    base_d   = base_q;
    sel_d    = sel_q;
    if (go_i) begin
      active_d = 1'b1;
      cnt_d    = '0;
      base_d   = base_i;
      sel_d    = sel_i;
    end else if (active_q) begin
      if (last_o) active_d = 1'b0;
      else        cnt_d    = cnt_q + IW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      base_q   <= '0;
      sel_q    <= 1'b0;
      we_q     <= 1'b0;
      widx_q   <= '0;
      wsel_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      base_q   <= base_d;
      sel_q    <= sel_d;
      // Read data returns one cycle later, so the element tag follows the read by one cycle.
      we_q     <= active_q;
      widx_q   <= cnt_q;
      wsel_q   <= sel_q;
    end
  end

  assign mem_rd_o   = active_q;
  assign mem_addr_o = base_q + AW'(cnt_q);
  assign we_o       = we_q;
  assign widx_o     = widx_q;
  assign wsel_o     = wsel_q;

endmodule

// File: rtl/dot_job_sequencer.sv
// Purpose : runs one MLP layer per start: loads X and each weight row into the
//           DotProduct operand buses, releases the engine and streams results out.
// Latency : per neuron VLEN reads + 1 capture + engine latency + 2; result valid the
//           cycle after a qualified endf.  Backpressure: out_valid held until out_ready.
//
// Ports: CLK/reset (async active-low); start/busy/done job control; mem_rd/mem_addr/
//   mem_rdata operand memory (1-cycle read); dp_reset/dp_a/dp_b/dp_result/dp_endf engine;
//   out_valid/out_ready/out_data/out_idx result stream; err sticky timeout flag.
// Option: define DOT_SEQ_TIMEOUT_EN to enable the RUN watchdog (TIMEOUT cycles, NaN result).
module dot_job_sequencer
  import mlp_pkg::*;
#(
  parameter int VLEN    = VLEN_DEF,
  parameter int NEURONS = NEURONS_DEF,
  parameter int AW      = 10,
  parameter int TIMEOUT = 4096
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd,
  output logic [AW-1:0]     mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              dp_reset,
  output logic [32*VLEN-1:0] dp_a,
  output logic [32*VLEN-1:0] dp_b,
  input  logic [31:0]       dp_result,
  input  logic              dp_endf,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [7:0]        out_idx,
  output logic              err
);

  localparam int IW = (VLEN > 1) ? $clog2(VLEN) : 1;

  seq_state_t    state_q, state_d;
  logic [7:0]    k_q, k_d;
  logic [31:0]   out_data_q, out_data_d;
  logic          done_q, done_d;
  logic          dp_reset_q, dp_reset_d;
  logic          armed_q;
  logic [32*VLEN-1:0] dp_a_q, dp_b_q;

  logic          ld_go, ld_sel, ld_last, ld_we, ld_wsel;
  logic [AW-1:0] ld_base;
  logic [IW-1:0] ld_widx;
  logic          endf_ok;

`ifdef DOT_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_q, err_d;
`endif

  operand_loader #(
    .VLEN (VLEN),
    .AW   (AW)
  ) u_loader (
    .clk_i      (CLK),
    .rst_ni     (reset),
    .go_i       (ld_go),
    .base_i     (ld_base),
    .sel_i      (ld_sel),
    .mem_rd_o   (mem_rd),
    .mem_addr_o (mem_addr),
    .last_o     (ld_last),
    .we_o       (ld_we),
    .widx_o     (ld_widx),
    .wsel_o     (ld_wsel)
  );

  // endf only counts once the engine has been out of reset for a full cycle, so a
  // flag left over from the previous job can never complete this one.
  assign endf_ok = (state_q == RUN) && !dp_reset_q && armed_q && dp_endf;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    out_data_d = out_data_q;
    done_d     = 1'b0;
    ld_go      = 1'b0;
    ld_sel     = 1'b0;
    ld_base    = '0;
`ifdef DOT_SEQ_TIMEOUT_EN
    err_d      = err_q;
    to_cnt_d   = (state_q == RUN) ? to_cnt_q + TO_W'(1) : '0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_X;
          k_d     = '0;
          ld_go   = 1'b1;
`ifdef DOT_SEQ_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      LOAD_X: begin
        if (ld_last) begin
          state_d = LOAD_W;
          ld_go   = 1'b1;
          ld_sel  = 1'b1;
          ld_base = AW'(row_base(VLEN, int'(k_q)));
        end
      end
      LOAD_W: begin
        if (ld_last) state_d = RUN;
      end
      RUN: begin
        if (endf_ok) begin
          out_data_d = dp_result;
          state_d    = EMIT;
        end
`ifdef DOT_SEQ_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          out_data_d = FP_QNAN;
          err_d      = 1'b1;
          state_d    = EMIT;
        end
`endif
      end
      EMIT: begin
        if (out_ready) begin
          if (k_q == 8'(NEURONS - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            k_d     = k_q + 8'd1;
            state_d = LOAD_W;
            ld_go   = 1'b1;
            ld_sel  = 1'b1;
            ld_base = AW'(row_base(VLEN, int'(k_q) + 1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Engine reset is registered: it stays high through the first RUN cycle while the
  // last weight word is written, and rises together with the move to EMIT.
  assign dp_reset_d = !((state_q == RUN) && (state_d == RUN));

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      k_q        <= '0;
      out_data_q <= '0;
      done_q     <= 1'b0;
      dp_reset_q <= 1'b1;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      out_data_q <= out_data_d;
      done_q     <= done_d;
      dp_reset_q <= dp_reset_d;
      armed_q    <= (state_q == RUN) && !dp_reset_q;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      dp_a_q <= '0;
      dp_b_q <= '0;
    end else if (ld_we) begin
      if (ld_wsel) dp_b_q[32*int'(ld_widx) +: 32] <= mem_rdata;
      else         dp_a_q[32*int'(ld_widx) +: 32] <= mem_rdata;
    end
  end

`ifdef DOT_SEQ_TIMEOUT_EN
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign dp_reset  = dp_reset_q;
  assign dp_a      = dp_a_q;
  assign dp_b      = dp_b_q;
  assign out_valid = (state_q == EMIT);
  assign out_data  = out_data_q;
  assign out_idx   = k_q;

endmodule

// File: tb/tb_dot_job_sequencer.sv
`timescale 1ns/1ps
module tb_dot_job_sequencer;

  localparam int VLEN    = 4;
  localparam int NEURONS = 2;
  localparam int AW      = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic              busy, done, mem_rd, dp_reset, out_valid, err;
  logic [AW-1:0]     mem_addr;
  logic [31:0]       mem_rdata = '0;
  logic [32*VLEN-1:0] dp_a, dp_b;
  logic [31:0]       dp_result;
  logic              dp_endf;
  logic              out_ready = 1'b1;
  logic [31:0]       out_data;
  logic [7:0]        out_idx;

  always #5 clk = ~clk;

  dot_job_sequencer #(
    .VLEN(VLEN), .NEURONS(NEURONS), .AW(AW), .TIMEOUT(20)
  ) dut (
    .CLK(clk), .reset(rst_n), .start(start), .busy(busy), .done(done),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .dp_reset(dp_reset), .dp_a(dp_a), .dp_b(dp_b), .dp_result(dp_result),
    .dp_endf(dp_endf), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .err(err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // ---------------- operand memory: X = 1.0, row0 = 2.0, row1 = 0.5 ----------------
  logic [31:0] mem [16];
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      mem[i]     = 32'h3F80_0000;
      mem[4 + i] = 32'h4000_0000;
      mem[8 + i] = 32'h3F00_0000;
    end
  end
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  // ---------------- behavioural engine: endf 5 cycles after dp_reset falls ----------------
  int          eng_cnt  = 0;
  logic        eng_endf = 1'b0;
  logic [31:0] eng_res  = '0;
  logic        stale    = 1'b0;
  bit          hang0    = 1'b0;

  function automatic logic [31:0] eng_calc(input logic [32*VLEN-1:0] a, input logic [32*VLEN-1:0] b);
    logic [31:0] w;
    w = b[31:0];
    for (int i = 0; i < VLEN; i++)
      if (a[32*i +: 32] !== 32'h3F80_0000 || b[32*i +: 32] !== w) return 32'hDEAD_0000;
    if (w == 32'h4000_0000) return 32'h4100_0000;  // 4 * 1.0 * 2.0
    if (w == 32'h3F00_0000) return 32'h4000_0000;  // 4 * 1.0 * 0.5
    return 32'hDEAD_0001;
  endfunction

  always @(posedge clk) begin
    if (dp_reset) begin
      eng_cnt  <= 0;
      eng_endf <= 1'b0;
      eng_res  <= '0;
    end else begin
      eng_cnt <= eng_cnt + 1;
      if (eng_cnt == 4 && !(hang0 && dp_b[31:0] == 32'h4000_0000)) begin
        eng_endf <= 1'b1;
        eng_res  <= eng_calc(dp_a, dp_b);
      end
    end
  end
  assign dp_endf   = eng_endf | stale;
  assign dp_result = eng_res;

  // ---------------- scoreboard and monitor ----------------
  typedef struct {
    logic [31:0] data;
    logic [7:0]  idx;
    bit          last;
  } exp_t;
  exp_t exp_q[$];

  exp_t        mon_e;
  bit          mon_hold = 1'b0;
  logic [31:0] mon_pd;
  logic [7:0]  mon_pi;
  bit          mon_nd = 1'b0;
  bit          mon_nr = 1'b0;

  always @(negedge clk) begin
    if (mon_nd) begin
      mon_nd = 1'b0;
      check("done_after_last_accept", done, 1'b1);
      check("busy_low_after_last_accept", busy, 1'b0);
    end
    if (mon_nr) begin
      mon_nr = 1'b0;
      check("row_read_after_accept", mem_rd, 1'b1);
    end
    if (rst_n && out_valid) begin
      if (mon_hold) begin
        check("held_data_stable", out_data, mon_pd);
        check("held_idx_stable", out_idx, mon_pi);
      end
      if (out_ready) begin
        mon_hold = 1'b0;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got %0h idx %0d, none expected", out_data, out_idx);
        end else begin
          mon_e = exp_q.pop_front();
          check("result_data", out_data, mon_e.data);
          check("result_idx", out_idx, mon_e.idx);
          if (mon_e.last) mon_nd = 1'b1;
          else            mon_nr = 1'b1;
        end
      end else begin
        mon_hold = 1'b1;
        mon_pd   = out_data;
        mon_pi   = out_idx;
      end
    end else begin
      mon_hold = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_normal();
    exp_q.push_back('{data: 32'h4100_0000, idx: 8'd0, last: 1'b0});
    exp_q.push_back('{data: 32'h4000_0000, idx: 8'd1, last: 1'b1});
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"},      busy,      1'b0);
    check({tag, "_done"},      done,      1'b0);
    check({tag, "_mem_rd"},    mem_rd,    1'b0);
    check({tag, "_mem_addr"},  mem_addr,  '0);
    check({tag, "_dp_reset"},  dp_reset,  1'b1);
    check({tag, "_dp_a"},      dp_a,      '0);
    check({tag, "_dp_b"},      dp_b,      '0);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_out_data"},  out_data,  '0);
    check({tag, "_out_idx"},   out_idx,   '0);
    check({tag, "_err"},       err,       1'b0);
  endtask

  // Cycle 0 carries the start pulse; returns the cycle index in which done is seen.
  task automatic run_layer(input bit with_stale, input bit dbl_start, output int lat);
    lat = -1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c < 400; c++) begin
      stale = with_stale && (c >= 5) && (c <= 10);
      start = dbl_start && (c == 12);
      @(negedge clk);
      if (c == 1) begin
        check("busy_after_start", busy, 1'b1);
        check("err_cleared_by_start", err, 1'b0);
      end
      if (dbl_start && c == 13) check("no_restart_while_busy", mem_rd, 1'b0);
      if (done) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    stale = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("done_single_pulse", done, 1'b0);
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    bit got;
    got = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check(name, got, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    bit found;

    #2 rst_n = 1'b0;
    #1 check_reset_vals("por");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    idle(2);

    // 1: nominal layer, consumer always ready.
    out_ready = 1'b1;
    push_normal();
    run_layer(1'b0, 1'b0, lat);
    check("nominal_latency", lat, 29);
    idle(3);

    // 2: consumer stalls the first result for 10 cycles.
    out_ready = 1'b0;
    push_normal();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (out_valid) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("stall_result_appears", found, 1'b1);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      check("stall_valid_held", out_valid, 1'b1);
      check("stall_data_held", out_data, 32'h4100_0000);
      check("stall_no_row_read", mem_rd, 1'b0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_done("stall_layer_done", 100);
    idle(3);

    // 3: stale endf through LOAD_W and the first RUN cycles must be ignored.
    push_normal();
    run_layer(1'b1, 1'b0, lat);
    check("stale_endf_latency", lat, 29);
    idle(3);

    // 4: reset asserted during the second LOAD_W aborts the layer.
    push_normal();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (mem_rd && out_idx == 8'd1) begin
        found = 1'b1;
        break;
      end
    end
    check("reached_second_load_w", found, 1'b1);
    exp_q.delete();
    rst_n = 1'b0;
    #1 check_reset_vals("abort");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    idle(6);
    check("abort_stays_idle", busy, 1'b0);
    push_normal();
    run_layer(1'b0, 1'b0, lat);
    check("post_abort_latency", lat, 29);
    idle(3);

    // 5: start pulsed while busy is ignored.
    push_normal();
    run_layer(1'b0, 1'b1, lat);
    check("busy_start_latency", lat, 29);
    idle(3);

`ifdef DOT_SEQ_TIMEOUT_EN
    // 6: engine never finishes row0 -> NaN result, sticky err, row1 still runs.
    hang0 = 1'b1;
    exp_q.push_back('{data: 32'h7FC0_0000, idx: 8'd0, last: 1'b0});
    exp_q.push_back('{data: 32'h4000_0000, idx: 8'd1, last: 1'b1});
    run_layer(1'b0, 1'b0, lat);
    check("timeout_latency", lat, 42);
    check("timeout_err_sticky", err, 1'b1);
    hang0 = 1'b0;
    idle(3);
    push_normal();
    run_layer(1'b0, 1'b0, lat);
    check("after_timeout_latency", lat, 29);
    check("err_clear_after_clean_layer", err, 1'b0);
    idle(3);
`endif

    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach the end, want completion");
    $fatal(1, "simulation time limit");
  end

endmodule
